fp_divider: RTL and testbench
=============================

# fp_divider

Sequential IEEE-754 single-precision divider computing result = A / B. It is the inverse operation to the floating-point multiplier and uses the same request/acknowledge handshake on `start_sig` / `done_sig`. Existing test benches and sequencers can therefore drive either unit unchanged. Quotient mantissa is produced by a restoring divider at one bit per clock; special operands bypass the iteration.

## Interface
- No parameters; format fixed at binary32 (1/8/23, bias 127).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `A`  in  32  dividend, binary32; sampled once, when the request is accepted.
- `B`  in  32  divisor, binary32; sampled with `A`.
- `start_sig`  in  1  request; the requester holds it high until it sees `done_sig[0]`, then drops it.
- `result`  out  32  quotient, binary32; held until the next completion.
- `done_sig`  out  4  status, all bits registered:
  - [0] done, a one-cycle pulse
  - [1] divide-by-zero
  - [2] overflow
  - [3] underflow

## Operation
- States: IDLE, CHECK, DIVIDE, NORM, DONE, RELEASE.
- **IDLE:** on `start_sig`=1, latch A/B, go to CHECK.
- **CHECK:** unpack operands. Denormal inputs are flushed to signed zero. Sign = sA ^ sB.
- **CHECK special cases (go directly to DONE):**
  - Either operand NaN, 0/0, or inf/inf: 0x7FC00000.
  - B=0 with A finite nonzero: sign|0x7F800000, bit[1]=1.
  - A=inf with B finite: signed infinity.
  - A=0 or B=inf, when not covered above: signed zero.
  - Otherwise go to DIVIDE.
- **DIVIDE:** restoring division of {1,mA} by {1,mB} (24-bit operands), 25 iterations, yielding q[24:0] with q[24] = integer bit.
- **Exponent:** e = eA − eB + 127, computed in 10-bit signed arithmetic.
- **NORM:**
  - If q[24]=1: mant = q[23:1], exponent e.
  - Else: mant = q[22:0], exponent e−1.
  - Rounding is truncation (toward zero).
  - Final e ≥ 255: signed infinity, bit[2]=1.
  - Final e ≤ 0: signed zero (no denormal output), bit[3]=1.
- **DONE:** `result` updated, `done_sig[0]`=1 for exactly one cycle, flags valid in the same cycle; go to RELEASE.
- **RELEASE:** wait until `start_sig`=0, then IDLE. A `start_sig` still high from the previous request never retriggers an operation.
- Inputs changing after acceptance have no effect.

## Timing
- **Reset values:** state IDLE, `result`=32'h0, `done_sig`=4'b0, all datapath registers zero.
- **Normal latency:** request sampled at edge t; `done_sig[0]` rises at edge t+27 (1 CHECK + 25 DIVIDE + 1 NORM) and falls at t+28.
- **Special-case latency:** `done_sig[0]` rises at edge t+2.
- **Flags:** `done_sig[3:1]` are valid only while `done_sig[0]`=1 and are cleared with it.
- **Turnaround:** minimum two cycles from `done_sig[0]` falling to the next acceptance, given the requester drops `start_sig` on the edge after done.
- **Reset mid-operation:** immediate abort, outputs return to reset values, no done pulse.
- **Iteration counter:** 5 bits, counts 0..24 with no wrap beyond 24.

## Structure
- **Shared package `fp_pkg`:**
  - Constants: bias (127), QNAN (32'h7FC00000), POS_INF (32'h7F800000), exponent and mantissa widths.
  - State-encoding typedef.
  - `done_sig` bit indices.
- **Sub-module `fp_div_mant_core`:** the iterative restoring divider, with load, busy and finished signals and a 25-bit quotient output. The top level holds the FSM, unpack, special cases and packing.

## Test plan
- **Normal divide:** 0x41700000 / 0x40A00000 (15/5) -> `result`=0x40400000, `done_sig`=4'b0001, done at edge t+27.
- **Truncation:** 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA, not 0x3EAAAAAB.
- **Sign and special cases:**
  - 0xC0C00000 / 0x40000000 (−6/2) -> 0xC0400000.
  - 0x40400000 / 0x00000000 -> 0x7F800000, `done_sig`=4'b0011, done at edge t+2.
  - 0x00000000 / 0x00000000 -> 0x7FC00000, bit[1]=0.
- **Overflow and underflow:**
  - 0x7F000000 / 0x3E800000 -> 0x7F800000, `done_sig`=4'b0101.
  - 0x00800000 / 0x40000000 -> 0x00000000, `done_sig`=4'b1001.
- **Handshake:**
  - Hold `start_sig` high for 10 cycles after done -> exactly one done pulse.
  - Drop and re-raise with a new A/B -> second result correct.
- **Reset:** assert `rst_n`=0 at edge t+10 of a normal divide -> outputs zero immediately, no done pulse; the next request completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the binary32 arithmetic units: format widths,
// special encodings, controller state encoding and done_sig bit positions.
package fp_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 23;
    localparam int unsigned SIG_W   = MAN_W + 1;   // significand incl. hidden bit
    localparam int unsigned QUO_W   = SIG_W + 1;   // quotient incl. integer bit
    localparam int unsigned CNT_W   = 5;           // iteration counter, 0..QUO_W-1
    localparam int unsigned ESUM_W  = 10;          // signed exponent arithmetic width
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;
    localparam int unsigned DONE_W  = 4;

    localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [WORD_W-1:0] POS_INF = 32'h7F80_0000;

    // done_sig bit indices
    localparam int unsigned DS_DONE = 0;
    localparam int unsigned DS_DIV0 = 1;
    localparam int unsigned DS_OVF  = 2;
    localparam int unsigned DS_UNF  = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_DIVIDE  = 3'd2,
        ST_NORM    = 3'd3,
        ST_DONE    = 3'd4,
        ST_RELEASE = 3'd5
    } state_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [MAN_W-1:0] mantissa;
    } fp32_t;

    function automatic logic [WORD_W-1:0] signed_inf(input logic s);
        return POS_INF | {s, {(WORD_W-1){1'b0}}};
    endfunction

    function automatic logic [WORD_W-1:0] signed_zero(input logic s);
        return {s, {(WORD_W-1){1'b0}}};
    endfunction

endpackage : fp_pkg

// File: rtl/fp_div_mant_core.sv
// Iterative restoring divider for 24-bit significands, one quotient bit per
// clock, QUO_W iterations. The first bit produced is the integer bit.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   load_i          start a new division (overrides any division in flight)
//   dividend_i      {1, mantissa A}
//   divisor_i       {1, mantissa B}
//   busy_o          iterations in progress (registered)
//   finished_c_o    combinational: the final iteration happens at this edge
//   quot_o          quotient q[24:0], valid once busy_o has dropped
module fp_div_mant_core
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [SIG_W-1:0] dividend_i,
    input  logic [SIG_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             finished_c_o,
    output logic [QUO_W-1:0] quot_o
);

    logic [SIG_W:0]   rem_q, rem_d;
    logic [SIG_W-1:0] dvs_q, dvs_d;
    logic [QUO_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [SIG_W+1:0] diff_c;
    logic [SIG_W:0]   rem_nxt_c;
    logic             ge_c;
    logic             last_c;

    // One restoring step: trial subtract, keep on no-borrow, shift left.
    always_comb begin
        diff_c    = {1'b0, rem_q} - {2'b00, dvs_q};
        ge_c      = ~diff_c[SIG_W+1];
        rem_nxt_c = ge_c ? diff_c[SIG_W:0] : rem_q;
        last_c    = busy_q && (cnt_q == CNT_W'(QUO_W - 1));

        rem_d  = rem_q;
        dvs_d  = dvs_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;

        if (load_i) begin
            rem_d  = {1'b0, dividend_i};
            dvs_d  = divisor_i;
            quo_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            quo_d = {quo_q[QUO_W-2:0], ge_c};
            rem_d = rem_nxt_c << 1;
            // Counter parks at its last value rather than wrapping.
            if (last_c) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o       = busy_q;
    assign finished_c_o = last_c;
    assign quot_o       = quo_q;

endmodule : fp_div_mant_core

// File: rtl/fp_divider.sv
// Sequential binary32 divider, result = A / B, truncating rounding,
// denormals flushed to zero on input and output.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   A, B         dividend / divisor, sampled when the request is accepted
//   start_sig    request, held high by the requester until done_sig[0]
//   result       quotient, held until the next completion
//   done_sig     {underflow, overflow, div-by-zero, done}; one-cycle pulse
module fp_divider
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              start_sig,
    output logic [WORD_W-1:0] result,
    output logic [DONE_W-1:0] done_sig
);

    state_e              state_q, state_d;
    fp32_t               a_q, a_d;
    fp32_t               b_q, b_d;
    logic                sign_q, sign_d;
    logic [ESUM_W-1:0]   exp_q, exp_d;
    logic [WORD_W-1:0]   pend_res_q, pend_res_d;
    logic [DONE_W-1:0]   pend_done_q, pend_done_d;
    logic [WORD_W-1:0]   result_q, result_d;
    logic [DONE_W-1:0]   done_q, done_d;

    logic                core_load_c;
    logic                core_busy;
    logic                core_fin_c;
    logic [QUO_W-1:0]    core_quo;

    logic a_nan_c, a_inf_c, a_zero_c;
    logic b_nan_c, b_inf_c, b_zero_c;
    logic [ESUM_W-1:0] e_norm_c;
    logic [MAN_W-1:0]  m_norm_c;
    logic              ovf_c, unf_c;

    // The core is loaded straight from the inputs on acceptance so that the
    // CHECK cycle overlaps the first iteration; special operands simply
    // ignore whatever the core produces.
    fp_div_mant_core u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (core_load_c),
        .dividend_i   ({1'b1, A[MAN_W-1:0]}),
        .divisor_i    ({1'b1, B[MAN_W-1:0]}),
        .busy_o       (core_busy),
        .finished_c_o (core_fin_c),
        .quot_o       (core_quo)
    );

    // Operand classification; exponent 0 covers zero and flushed denormals.
    always_comb begin
        a_nan_c  = (a_q.exponent == '1) && (a_q.mantissa != '0);
        a_inf_c  = (a_q.exponent == '1) && (a_q.mantissa == '0);
        a_zero_c = (a_q.exponent == '0);
        b_nan_c  = (b_q.exponent == '1) && (b_q.mantissa != '0);
        b_inf_c  = (b_q.exponent == '1) && (b_q.mantissa == '0);
        b_zero_c = (b_q.exponent == '0);
    end

    // Normalisation of the quotient and range checks on the final exponent.
    always_comb begin
        if (core_quo[QUO_W-1]) begin
            m_norm_c = core_quo[QUO_W-2:1];
            e_norm_c = exp_q;
        end else begin
            m_norm_c = core_quo[MAN_W-1:0];
            e_norm_c = exp_q - ESUM_W'(1);
        end
        ovf_c = $signed(e_norm_c) >= $signed(ESUM_W'(EXP_MAX));
        unf_c = $signed(e_norm_c) <  $signed(ESUM_W'(1));
    end

    // Controller next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        pend_res_d  = pend_res_q;
        pend_done_d = pend_done_q;
        result_d    = result_q;
        done_d      = '0;
        core_load_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_sig) begin
                    a_d         = A;
                    b_d         = B;
                    core_load_c = 1'b1;
                    state_d     = ST_CHECK;
                end
            end

            ST_CHECK: begin
                sign_d = a_q.sign ^ b_q.sign;
                exp_d  = ESUM_W'(a_q.exponent) - ESUM_W'(b_q.exponent) + ESUM_W'(BIAS);
                pend_done_d          = '0;
                pend_done_d[DS_DONE] = 1'b1;
                state_d              = ST_DONE;
                if (a_nan_c || b_nan_c || (a_zero_c && b_zero_c) || (a_inf_c && b_inf_c)) begin
                    pend_res_d = QNAN;
                end else if (b_zero_c && !a_inf_c) begin
                    pend_res_d           = signed_inf(a_q.sign ^ b_q.sign);
                    pend_done_d[DS_DIV0] = 1'b1;
                end else if (a_inf_c) begin
                    pend_res_d = signed_inf(a_q.sign ^ b_q.sign);
                end else if (a_zero_c || b_inf_c) begin
                    pend_res_d = signed_zero(a_q.sign ^ b_q.sign);
                end else begin
                    state_d = ST_DIVIDE;
                end
            end

            ST_DIVIDE: begin
                // !core_busy only guards against ever stalling here.
                if (core_fin_c || !core_busy) begin
                    state_d = ST_NORM;
                end
            end

            ST_NORM: begin
                pend_done_d          = '0;
                pend_done_d[DS_DONE] = 1'b1;
                if (ovf_c) begin
                    pend_res_d          = signed_inf(sign_q);
                    pend_done_d[DS_OVF] = 1'b1;
                end else if (unf_c) begin
                    pend_res_d          = signed_zero(sign_q);
                    pend_done_d[DS_UNF] = 1'b1;
                end else begin
                    pend_res_d = {sign_q, e_norm_c[EXP_W-1:0], m_norm_c};
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                result_d = pend_res_q;
                done_d   = pend_done_q;
                state_d  = ST_RELEASE;
            end

            ST_RELEASE: begin
                // A request still held from the last operation must not retrigger.
                if (!start_sig) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            pend_res_q  <= '0;
            pend_done_q <= '0;
            result_q    <= '0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            pend_res_q  <= pend_res_d;
            pend_done_q <= pend_done_d;
            result_q    <= result_d;
            done_q      <= done_d;
        end
    end

    assign result   = result_q;
    assign done_sig = done_q;

endmodule : fp_divider

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed vector table, randomized
// operands against an arithmetic reference model, handshake and reset cases.
module tb_fp_divider;

    localparam int MAXC = 60;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic        start_sig;
    logic [31:0] result;
    logic [3:0]  done_sig;

    int checks = 0;
    int errors = 0;

    fp_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .start_sig (start_sig),
        .result    (result),
        .done_sig  (done_sig)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } vec_t;

    vec_t        vecs[14];
    logic [31:0] specials[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: quotient from integer division of the scaled significands.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] d,
                                  output int lat);
        logic   s    = a[31] ^ b[31];
        int     ea   = int'(a[30:23]);
        int     eb   = int'(b[30:23]);
        longint ma   = longint'(a[22:0]);
        longint mb   = longint'(b[22:0]);
        bit     nan_a = (ea == 255) && (ma != 0);
        bit     nan_b = (eb == 255) && (mb != 0);
        bit     inf_a = (ea == 255) && (ma == 0);
        bit     inf_b = (eb == 255) && (mb == 0);
        bit     z_a   = (ea == 0);
        bit     z_b   = (eb == 0);
        longint q;
        longint mant;
        int     e;
        lat = 2;
        d   = 4'b0001;
        if (nan_a || nan_b || (z_a && z_b) || (inf_a && inf_b)) begin
            r = 32'h7FC00000;
        end else if (z_b && !inf_a) begin
            r = {s, 8'hFF, 23'h0};
            d = 4'b0011;
        end else if (inf_a) begin
            r = {s, 8'hFF, 23'h0};
        end else if (z_a || inf_b) begin
            r = {s, 31'h0};
        end else begin
            lat = 27;
            q = ((ma + 64'h800000) * 64'h1000000) / (mb + 64'h800000);
            e = ea - eb + 127;
            if (q >= 64'h1000000) begin
                mant = (q / 2) % 64'h800000;
            end else begin
                mant = q % 64'h800000;
                e    = e - 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'h0};
                d = 4'b0101;
            end else if (e <= 0) begin
                r = {s, 31'h0};
                d = 4'b1001;
            end else begin
                r = {s, 8'(e), 23'(mant)};
            end
        end
    endfunction

    // Issue one request; operands are scrambled right after acceptance.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [3:0] d,
                          output int lat, output bit tmo, output logic [3:0] after);
        @(negedge clk);
        A = a;
        B = b;
        start_sig = 1'b1;
        @(posedge clk);
        #1;
        A = $urandom;
        B = $urandom;
        lat = 0;
        tmo = 1'b1;
        for (int i = 1; i <= MAXC; i++) begin
            if (i > 1) #1;
            @(posedge clk);
            #1;
            if (done_sig[0]) begin
                lat = i;
                tmo = 1'b0;
                break;
            end
        end
        r = result;
        d = done_sig;
        start_sig = 1'b0;
        @(posedge clk);
        #1;
        after = done_sig;
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic [3:0] ed, input int el);
        logic [31:0] r;
        logic [3:0]  d;
        logic [3:0]  after;
        int          lat;
        bit          tmo;
        run_op(a, b, r, d, lat, tmo, after);
        if (tmo) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, MAXC);
        end else begin
            chk({name, " result"}, r, er);
            chk({name, " done_sig"}, 32'(d), 32'(ed));
            chk({name, " latency"}, 32'(lat), 32'(el));
            chk({name, " pulse end"}, 32'(after), 32'h0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] er;
        logic [3:0]  ed;
        int          el;
        int          got;
        int          extra;

        vecs[0]  = '{32'h41700000, 32'h40A00000, 32'h40400000, 4'b0001, 27};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0001, 27};
        vecs[2]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0001, 27};
        vecs[3]  = '{32'h40400000, 32'h00000000, 32'h7F800000, 4'b0011, 2};
        vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 2};
        vecs[5]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0101, 27};
        vecs[6]  = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b1001, 27};
        vecs[7]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0001, 2};
        vecs[8]  = '{32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0001, 2};
        vecs[9]  = '{32'h7FC00123, 32'h3F800000, 32'h7FC00000, 4'b0001, 2};
        vecs[10] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0001, 2};
        vecs[11] = '{32'hC0000000, 32'h00000000, 32'hFF800000, 4'b0011, 2};
        vecs[12] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0001, 2};
        vecs[13] = '{32'h7F800000, 32'h80000000, 32'hFF800000, 4'b0001, 2};

        specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                     32'h7FC00000, 32'h00400000, 32'h7F800001, 32'h3F800000};

        rst_n = 1'b0;
        start_sig = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset result", result, 32'h0);
        chk("reset done_sig", 32'(done_sig), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                     vecs[i].res, vecs[i].flg, vecs[i].lat);
        end

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    ra = $urandom;
                    rb = $urandom;
                end
                1: begin
                    ra = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
                    rb = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
                end
                2: begin
                    if ($urandom_range(0, 1) == 1) begin
                        ra = {1'($urandom), 8'($urandom_range(200, 254)), 23'($urandom)};
                        rb = {1'($urandom), 8'($urandom_range(1, 60)), 23'($urandom)};
                    end else begin
                        ra = {1'($urandom), 8'($urandom_range(1, 60)), 23'($urandom)};
                        rb = {1'($urandom), 8'($urandom_range(190, 254)), 23'($urandom)};
                    end
                end
                default: begin
                    ra = specials[$urandom_range(0, 7)];
                    rb = ($urandom_range(0, 1) == 1) ? specials[$urandom_range(0, 7)] : $urandom;
                end
            endcase
            model(ra, rb, er, ed, el);
            check_op($sformatf("rand%0d a=%h b=%h", n, ra, rb), ra, rb, er, ed, el);
        end

        // Request held high after completion must yield exactly one pulse.
        @(negedge clk);
        A = 32'h41700000;
        B = 32'h40A00000;
        start_sig = 1'b1;
        @(posedge clk);
        got = 0;
        for (int i = 0; i < MAXC; i++) begin
            @(posedge clk);
            #1;
            if (done_sig[0]) begin
                got = 1;
                break;
            end
        end
        chk("hs first done seen", 32'(got), 32'h1);
        chk("hs first result", result, 32'h40400000);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done_sig[0]) extra++;
        end
        chk("hs held start extra pulses", 32'(extra), 32'h0);
        start_sig = 1'b0;
        @(posedge clk);
        model(32'hC0C00000, 32'h40000000, er, ed, el);
        check_op("hs second", 32'hC0C00000, 32'h40000000, er, ed, el);

        // Reset in the middle of a normal divide aborts without a pulse.
        @(negedge clk);
        A = 32'h41700000;
        B = 32'h40A00000;
        start_sig = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start_sig = 1'b0;
        #1;
        chk("rst abort result", result, 32'h0);
        chk("rst abort done_sig", 32'(done_sig), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            if (done_sig[0]) extra++;
        end
        chk("rst no done pulse", 32'(extra), 32'h0);
        check_op("post reset", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0001, 27);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fp_divider
